blockram_dual: RTL and testbench

//  Two-port block RAM controller for the pipeconnect bus: two masters (e.g. I-side, D-side) share one

---
 rtl/blockram_dual_pkg.sv | 37 +++
 rtl/blockram_arb2.sv | 35 +++
 rtl/dpram.sv | 40 ++++
 rtl/blockram_dual.sv | 157 +++++++++++++++
 tb/tb_blockram_dual.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/blockram_dual_pkg.sv
// rtl/blockram_dual_pkg.sv - shared bus bundles, FSM encoding and helpers for blockram_dual
//
// Purpose: pipeconnect request/response bundles and the per-port FSM state
// encoding. Benches import this package too.
package blockram_dual_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = WORD_W / 8;

  // Master -> RAM request: address, read, write, write data, byte enables.
  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic              r;
    logic              w;
    logic [WORD_W-1:0] wd;
    logic [BE_W-1:0]   wbe;
  } req_t;

  // RAM -> master response: stall and read data.
  typedef struct packed {
    logic              hold;
    logic [WORD_W-1:0] rd;
  } res_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // A port may compete for the array only from IDLE or REQ.
  function automatic logic can_arbitrate(input state_t s);
    return (s == ST_IDLE) || (s == ST_REQ);
  endfunction

endpackage

// File: rtl/blockram_arb2.sv
// rtl/blockram_arb2.sv - two-way fixed-priority / round-robin arbiter
//
// Purpose: picks at most one of two eligible ports per cycle.
// Ports: clock, rst (async active-low), eligible[1:0] in, grant[1:0] one-hot out.
module blockram_arb2 #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [1:0] eligible,
  output logic [1:0] grant
);

  // Port that won most recently; reset to 1 so port 0 takes the first conflict.
  logic last_grant;

  always_comb begin
    grant = 2'b00;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (ROUND_ROBIN && !last_grant) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/dpram.sv
// rtl/dpram.sv - two-port synchronous RAM with byte enables
//
// Purpose: 2^AW x 32-bit array, registered read address (q valid the cycle
// after the address is presented), per-byte write enables on both ports.
// Ports: clock; port a/b each with address, data, byteena, wren, q.
module dpram #(
  parameter int    AW        = 18,
  parameter string INIT_FILE = ""
) (
  input  logic          clock,
  input  logic [AW-1:0] address_a,
  input  logic [31:0]   data_a,
  input  logic [3:0]    byteena_a,
  input  logic          wren_a,
  output logic [31:0]   q_a,
  input  logic [AW-1:0] address_b,
  input  logic [31:0]   data_b,
  input  logic [3:0]    byteena_b,
  input  logic          wren_b,
  output logic [31:0]   q_b
);

  logic [31:0] mem [0:(1<<AW)-1];

  if (INIT_FILE != "") begin : g_init_note
    $warning("dpram: INIT_FILE preload is not applied by this array model");
  end

  // Both ports share one process so the array has a single driver; port b
  // wins a same-byte write collision.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (wren_a && byteena_a[i]) mem[address_a][8*i +: 8] <= data_a[8*i +: 8];
      if (wren_b && byteena_b[i]) mem[address_b][8*i +: 8] <= data_b[8*i +: 8];
    end
    q_a <= mem[address_a];
    q_b <= mem[address_b];
  end

endmodule

// File: rtl/blockram_dual.sv
// rtl/blockram_dual.sv - two-master pipeconnect controller over one single-ported RAM
//
// Purpose: per-port handshake FSMs, 2-way arbitration, region decode on
// A[31:28] and 1- or 2-cycle read latency.
// Ports: clock; rst (async active-low); req0/req1 request bundles in;
// res0/res1 response bundles (hold, rd) out.
module blockram_dual
  import blockram_dual_pkg::*;
#(
  parameter int         SIZE        = 18,
  parameter logic [3:0] BASE        = 4'h4,
  parameter int         RD_LATENCY  = 1,
  parameter bit         ROUND_ROBIN = 1'b1,
  parameter string      INIT_FILE   = ""
) (
  input  logic clock,
  input  logic rst,
  input  req_t req0,
  output res_t res0,
  input  req_t req1,
  output res_t res1
);

  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("blockram_dual: RD_LATENCY must be 1 or 2");
  end

  req_t req [2];
  res_t res [2];

  assign req[0] = req0;
  assign req[1] = req1;
  assign res0   = res[0];
  assign res1   = res[1];

  logic [1:0] eligible;
  logic [1:0] grant;

  blockram_arb2 #(.ROUND_ROBIN(ROUND_ROBIN)) u_arb (
    .clock    (clock),
    .rst      (rst),
    .eligible (eligible),
    .grant    (grant)
  );

  // Array access is steered by the single granted port.
  logic            gnt_port;
  logic [SIZE-1:0] ram_addr;
  logic [31:0]     ram_wd;
  logic [3:0]      ram_be;
  logic            ram_wren;
  logic [31:0]     ram_q;
  logic [31:0]     unused_q_b;

  assign gnt_port = grant[1];

  always_comb begin
    ram_addr = req[gnt_port].a[SIZE+1:2];
    ram_wd   = req[gnt_port].wd;
    ram_be   = req[gnt_port].wbe;
    ram_wren = (|grant) & req[gnt_port].w;
  end

  dpram #(.AW(SIZE), .INIT_FILE(INIT_FILE)) u_ram (
    .clock     (clock),
    .address_a (ram_addr),
    .data_a    (ram_wd),
    .byteena_a (ram_be),
    .wren_a    (ram_wren),
    .q_a       (ram_q),
    .address_b ('0),
    .data_b    ('0),
    .byteena_b ('0),
    .wren_b    (1'b0),
    .q_b       (unused_q_b)
  );

  // Tag each access with its port so that, with two overlapping reads in
  // flight, each completing port only ever sees the data it asked for.
  logic        s1_valid, s1_port;
  logic        out_valid, out_port;
  logic [31:0] out_data;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_port  <= 1'b0;
    end else begin
      s1_valid <= |grant;
      s1_port  <= gnt_port;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic        s2_valid, s2_port;
    logic [31:0] q_reg;
    always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
        s2_valid <= 1'b0;
        s2_port  <= 1'b0;
        q_reg    <= '0;
      end else begin
        s2_valid <= s1_valid;
        s2_port  <= s1_port;
        q_reg    <= ram_q;
      end
    end
    assign out_valid = s2_valid;
    assign out_port  = s2_port;
    assign out_data  = q_reg;
  end else begin : g_lat1
    assign out_valid = s1_valid;
    assign out_port  = s1_port;
    assign out_data  = ram_q;
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    state_t state_q, state_d;
    logic   active, selected, hold, rd_hit;

    assign active   = req[p].r | req[p].w;
    assign selected = (req[p].a[31:28] == BASE);
    // Gated by rst so nothing reaches the array while held in reset.
    assign eligible[p] = rst & active & selected & can_arbitrate(state_q);

    always_comb begin
      state_d = state_q;
      case (state_q)
        ST_IDLE, ST_REQ: begin
          if (!active)        state_d = ST_IDLE;
          else if (!selected) state_d = ST_DONE;
          else if (grant[p])  state_d = (req[p].r && RD_LATENCY == 2) ? ST_BUSY : ST_DONE;
          else                state_d = ST_REQ;
        end
        // A master that gives up mid-read lets the access drain unseen.
        ST_BUSY: state_d = active ? ST_DONE : ST_IDLE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge clock or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
    end

    assign hold   = active & (state_q != ST_DONE);
    assign rd_hit = (state_q == ST_DONE) & req[p].r & selected &
                    out_valid & (out_port == 1'(p));
    assign res[p] = '{hold: hold, rd: (rd_hit ? out_data : 32'h0)};
  end

  // Bits outside the word index are don't-care within the region.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req[0].a, req[1].a};

endmodule

// File: tb/tb_blockram_dual.sv
// tb/tb_blockram_dual.sv - directed self-checking bench for blockram_dual
module tb_blockram_dual;
  import blockram_dual_pkg::*;

  logic clock = 1'b0;
  logic rst;
  always #5 clock = ~clock;

  // u1: lat 1 RR; u3: lat 1 fixed priority (shares u1 stimulus); u2: lat 2 RR.
  req_t ra0, ra1, rb0, rb1;
  res_t r1_0, r1_1, r3_0, r3_1, r2_0, r2_1;

  blockram_dual #(.RD_LATENCY(1), .ROUND_ROBIN(1'b1)) u1 (
    .clock(clock), .rst(rst), .req0(ra0), .res0(r1_0), .req1(ra1), .res1(r1_1));
  blockram_dual #(.RD_LATENCY(1), .ROUND_ROBIN(1'b0)) u3 (
    .clock(clock), .rst(rst), .req0(ra0), .res0(r3_0), .req1(ra1), .res1(r3_1));
  blockram_dual #(.RD_LATENCY(2), .ROUND_ROBIN(1'b1)) u2 (
    .clock(clock), .rst(rst), .req0(rb0), .res0(r2_0), .req1(rb1), .res1(r2_1));

  int n_tests = 0;
  int n_fail  = 0;

  logic        d_hold1, d_hold3;
  logic [31:0] d_rd1, d_rd3;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic req_t mk(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] wbe);
    req_t q;
    q.a = a; q.r = r; q.w = w; q.wd = wd; q.wbe = wbe;
    return q;
  endfunction

  // Solo transfer on the lat-1 pair; captures the completion-cycle response.
  task automatic xfer_a(input bit port, input req_t q);
    cyc();
    if (port) ra1 = q; else ra0 = q;
    cyc();
    #1;
    d_hold1 = port ? r1_1.hold : r1_0.hold;
    d_rd1   = port ? r1_1.rd   : r1_0.rd;
    d_hold3 = port ? r3_1.hold : r3_0.hold;
    d_rd3   = port ? r3_1.rd   : r3_0.rd;
    cyc();
    ra0 = '0;
    ra1 = '0;
  endtask

  initial begin
    rst = 1'b0;
    ra0 = '0; ra1 = '0; rb0 = '0; rb1 = '0;

    // Reset: hold follows the request, rd stays 0.
    ra0 = mk(1'b1, 1'b0, 32'h4000_0000, '0, '0);
    cyc(); cyc();
    chk("rst_hold_follows_req", 32'(r1_0.hold), 32'd1);
    chk("rst_rd_zero", r1_0.rd, 32'h0);
    chk("rst_idle_hold", 32'(r2_0.hold), 32'd0);
    ra0 = '0;
    cyc();
    rst = 1'b1;

    // 1: lat 1 write then read back.
    cyc();
    ra0 = mk(1'b0, 1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF);
    #1;
    chk("t1_w_grant_hold", 32'(r1_0.hold), 32'd1);
    cyc(); #1;
    chk("t1_w_done_hold", 32'(r1_0.hold), 32'd0);
    cyc();
    ra0 = mk(1'b1, 1'b0, 32'h4000_0010, '0, '0);
    #1;
    chk("t1_r_grant_hold", 32'(r1_0.hold), 32'd1);
    chk("t1_r_grant_rd", r1_0.rd, 32'h0);
    cyc(); #1;
    chk("t1_r_done_hold", 32'(r1_0.hold), 32'd0);
    chk("t1_r_done_rd", r1_0.rd, 32'hDEAD_BEEF);
    chk("t1_r_done_rd_fp", r3_0.rd, 32'hDEAD_BEEF);
    cyc();
    ra0 = '0;
    #1;
    chk("t1_rd_after", r1_0.rd, 32'h0);

    // Preload conflict words via port 1 (leaves last_grant = 1).
    xfer_a(1'b1, mk(1'b0, 1'b1, 32'h4000_0020, 32'h1111_1111, 4'hF));
    xfer_a(1'b1, mk(1'b0, 1'b1, 32'h4000_0024, 32'h2222_2222, 4'hF));

    // 3: simultaneous reads from idle, two rounds -> grants 0,1,0,1.
    for (int k = 0; k < 2; k++) begin
      cyc();
      ra0 = mk(1'b1, 1'b0, 32'h4000_0020, '0, '0);
      ra1 = mk(1'b1, 1'b0, 32'h4000_0024, '0, '0);
      #1;
      chk("t3_both_hold0", 32'(r1_0.hold), 32'd1);
      chk("t3_both_hold1", 32'(r1_1.hold), 32'd1);
      cyc(); #1;
      chk("t3_rr_p0_done", 32'(r1_0.hold), 32'd0);
      chk("t3_rr_p0_rd", r1_0.rd, 32'h1111_1111);
      chk("t3_rr_p1_wait", 32'(r1_1.hold), 32'd1);
      chk("t3_rr_p1_rd0", r1_1.rd, 32'h0);
      chk("t3_fp_p0_rd", r3_0.rd, 32'h1111_1111);
      chk("t3_fp_p1_wait", 32'(r3_1.hold), 32'd1);
      cyc();
      ra0 = '0;
      #1;
      chk("t3_rr_p1_done", 32'(r1_1.hold), 32'd0);
      chk("t3_rr_p1_rd", r1_1.rd, 32'h2222_2222);
      chk("t3_fp_p1_rd", r3_1.rd, 32'h2222_2222);
      cyc();
      ra1 = '0;
    end

    // 3b: after a port-0 grant, RR favours port 1; fixed priority still port 0.
    xfer_a(1'b0, mk(1'b1, 1'b0, 32'h4000_0020, '0, '0));
    chk("t3b_solo_rd", d_rd1, 32'h1111_1111);
    cyc();
    ra0 = mk(1'b1, 1'b0, 32'h4000_0020, '0, '0);
    ra1 = mk(1'b1, 1'b0, 32'h4000_0024, '0, '0);
    cyc(); #1;
    chk("t3b_rr_p1_first", r1_1.rd, 32'h2222_2222);
    chk("t3b_rr_p0_wait", 32'(r1_0.hold), 32'd1);
    chk("t3b_fp_p0_first", r3_0.rd, 32'h1111_1111);
    chk("t3b_fp_p1_wait", 32'(r3_1.hold), 32'd1);
    cyc();
    ra0 = '0;
    ra1 = '0;

    // 4: byte enables, including an all-zero WBE write.
    xfer_a(1'b0, mk(1'b0, 1'b1, 32'h4000_0030, 32'hFFFF_FFFF, 4'hF));
    xfer_a(1'b0, mk(1'b0, 1'b1, 32'h4000_0030, 32'h0000_0000, 4'h5));
    xfer_a(1'b0, mk(1'b1, 1'b0, 32'h4000_0030, '0, '0));
    chk("t4_be5_rd", d_rd1, 32'hFF00_FF00);
    xfer_a(1'b0, mk(1'b0, 1'b1, 32'h4000_0030, 32'h1234_5678, 4'h0));
    chk("t4_be0_done", 32'(d_hold1), 32'd0);
    xfer_a(1'b1, mk(1'b1, 1'b0, 32'h4000_0030, '0, '0));
    chk("t4_be0_unchanged", d_rd1, 32'hFF00_FF00);

    // 5: unselected region, then alias above the array index.
    xfer_a(1'b0, mk(1'b1, 1'b0, 32'h8000_0000, '0, '0));
    chk("t5_unsel_hold", 32'(d_hold1), 32'd0);
    chk("t5_unsel_rd", d_rd1, 32'h0);
    xfer_a(1'b0, mk(1'b0, 1'b1, 32'h8000_0010, 32'h0000_0000, 4'hF));
    xfer_a(1'b0, mk(1'b1, 1'b0, 32'h4000_0010, '0, '0));
    chk("t5_word4_kept", d_rd1, 32'hDEAD_BEEF);
    xfer_a(1'b1, mk(1'b1, 1'b0, 32'h4040_0010, '0, '0));
    chk("t5_alias_rd", d_rd1, 32'hDEAD_BEEF);
    chk("t5_alias_rd_fp", d_rd3, 32'hDEAD_BEEF);

    // 2: lat 2, port 1 write then read.
    cyc();
    rb1 = mk(1'b0, 1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF);
    cyc(); #1;
    chk("t2_w_done_hold", 32'(r2_1.hold), 32'd0);
    cyc();
    rb1 = mk(1'b1, 1'b0, 32'h4000_0010, '0, '0);
    #1;
    chk("t2_c1_hold", 32'(r2_1.hold), 32'd1);
    chk("t2_c1_rd", r2_1.rd, 32'h0);
    cyc(); #1;
    chk("t2_c2_hold", 32'(r2_1.hold), 32'd1);
    chk("t2_c2_rd", r2_1.rd, 32'h0);
    cyc(); #1;
    chk("t2_c3_hold", 32'(r2_1.hold), 32'd0);
    chk("t2_c3_rd", r2_1.rd, 32'hDEAD_BEEF);
    cyc();
    rb1 = '0;
    #1;
    chk("t2_after_rd", r2_1.rd, 32'h0);

    // Lat 2 pipelining: write/read-after-write across ports, overlapped reads.
    cyc();
    rb0 = mk(1'b0, 1'b1, 32'h4000_0040, 32'hA5A5_A5A5, 4'hF);
    cyc();
    rb1 = mk(1'b1, 1'b0, 32'h4000_0040, '0, '0);
    #1;
    chk("tp_w_done", 32'(r2_0.hold), 32'd0);
    chk("tp_p1_grant_hold", 32'(r2_1.hold), 32'd1);
    cyc();
    rb0 = mk(1'b1, 1'b0, 32'h4000_0010, '0, '0);
    #1;
    chk("tp_p1_busy_rd", r2_1.rd, 32'h0);
    cyc(); #1;
    chk("tp_p1_raw_rd", r2_1.rd, 32'hA5A5_A5A5);
    chk("tp_p0_busy_rd", r2_0.rd, 32'h0);
    chk("tp_p0_busy_hold", 32'(r2_0.hold), 32'd1);
    cyc();
    rb1 = '0;
    #1;
    chk("tp_p0_rd", r2_0.rd, 32'hDEAD_BEEF);
    chk("tp_p1_quiet", r2_1.rd, 32'h0);
    cyc();
    rb0 = '0;

    // 6: reset while a lat-2 read is in BUSY; held request re-runs afterwards.
    cyc();
    rb0 = mk(1'b1, 1'b0, 32'h4000_0010, '0, '0);
    cyc();
    rst = 1'b0;
    #1;
    chk("t6_rst_rd", r2_0.rd, 32'h0);
    chk("t6_rst_hold", 32'(r2_0.hold), 32'd1);
    cyc(); #1;
    chk("t6_rst_rd2", r2_0.rd, 32'h0);
    cyc();
    rst = 1'b1;
    #1;
    chk("t6_rel_hold", 32'(r2_0.hold), 32'd1);
    cyc(); #1;
    chk("t6_busy_rd", r2_0.rd, 32'h0);
    cyc(); #1;
    chk("t6_done_hold", 32'(r2_0.hold), 32'd0);
    chk("t6_done_rd", r2_0.rd, 32'hDEAD_BEEF);
    cyc();
    rb0 = '0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
